acc_mem_responder: RTL and testbench
====================================

// Module: acc_mem_responder
// PURPOSE
//   Word-addressed memory that answers the accumulator controller's ReadEnable/WriteEnable/Address requests.
//   Holds the operand words the controller reads and stores the partial sums it writes back.
//   Read data returns 2 cycles after the request, lining up with the controller's request/wait/load cadence.
//   After every reset it clears its whole array before accepting requests.
// PARAMETERS
//   DATA_W      16   width of one stored word
//   ADDR_W      6    address width; DEPTH = 2**ADDR_W = 64 words
//   INIT_VALUE  0    value written to every word by the post-reset clear sweep
// PORTS
//   Clock        in   1        single clock; all logic on rising edge
//   Reset        in   1        synchronous, active-high
//   Address      in   ADDR_W   word address for the read or write request
//   ReadEnable   in   1        read request, sampled each cycle
//   WriteEnable  in   1        write request, sampled each cycle
//   WriteData    in   DATA_W   data for a write
//   ReadData     out  DATA_W   read result, meaningful only while ReadValid=1
//   ReadValid    out  1        one-cycle pulse per accepted read
//   MemReady     out  1        1 = clear sweep done and requests are accepted
//   ParityError  out  1        present only with ACC_MEM_PARITY_EN
// BEHAVIOUR
//   Reset values: ReadData=0, ReadValid=0, MemReady=0, ParityError=0, sweep counter=0, pipeline flushed.
//   Array contents are NOT reset. They are rewritten by the sweep.
//   FSM states:
//     S_INIT: one word per cycle. mem[cnt]<=INIT_VALUE, cnt++.
//             After cnt==DEPTH-1 is written -> S_IDLE. The sweep takes exactly DEPTH cycles.
//     S_IDLE: MemReady=1. Stays here until Reset.
//   Requests while MemReady=0 are ignored: no write, no ReadValid.
//   Read: ReadEnable=1 at edge N (in S_IDLE) -> ReadData valid with ReadValid=1 in the cycle after edge N+2.
//     Stage 1 registers the address. Stage 2 reads the array into ReadData.
//     A read is accepted every cycle, giving full throughput.
//     A ReadEnable held for k cycles yields k ReadValid pulses.
//   Write: WriteEnable=1 at edge N -> mem[Address]<=WriteData at edge N. Single-cycle, no response signal.
//   ReadEnable and WriteEnable both high: the write is done and the read is dropped (no ReadValid).
//   Write to an address while a read of that address sits in stage 1: stage 2 returns the NEW data (write-first bypass).
//   ReadData holds its last value when ReadValid=0.
//   Address wrap: only the low ADDR_W bits are used. There is no out-of-range case.
//   Reset mid-operation:
//     in-flight reads are discarded and ReadValid stays 0
//     a write sampled on the same edge as Reset=1 is discarded
//     the sweep restarts from 0
// CONFIGURATION
//   ACC_MEM_PARITY_EN defined:
//     each word stores one extra even-parity bit computed from WriteData; the sweep stores the parity of INIT_VALUE
//     stage 2 recomputes parity; a mismatch gives ParityError=1 together with ReadValid, and 0 otherwise
//   Not defined: no parity storage, the ParityError port does not exist, array width is DATA_W.
// STRUCTURE
//   Package acc_mem_pkg holds:
//     state encodings S_INIT / S_IDLE
//     default DATA_W and ADDR_W
//     parity function parity_of()
//   Sub-module acc_mem_array is a plain 1W/1R synchronous-read storage; the parity bit is appended when enabled.
//   The FSM, sweep counter, read pipeline and bypass stay in acc_mem_responder.
// TESTING
//   1. Reset=1 for 1 cycle, then 0:
//      - MemReady=0 for exactly 64 cycles, then 1
//      - reading any address gives ReadData=0x0000
//   2. Write addr 5=0x1234, then ReadEnable at addr 5 for 3 cycles:
//      - first ReadValid is 2 cycles after the first request
//      - 3 pulses, all with ReadData=0x1234
//   3. Write 8 words 0x0001..0x0008 at addrs 0..7, then read 0..7 back-to-back:
//      - 8 consecutive ReadValid cycles
//      - data comes back in order
//   4. Read addr 9 at N and write addr 9=0xBEEF at N+1:
//      - ReadValid returns 0xBEEF
//   5. ReadEnable and WriteEnable both high, addr 3=0x00AA:
//      - no ReadValid pulse
//      - a later read of addr 3 returns 0x00AA
//   6. Assert Reset while 2 reads are in flight:
//      - no ReadValid pulses
//      - sweep restarts and a written word reads back 0 afterwards
//      - with ACC_MEM_PARITY_EN: force a stored parity bit flip, then read -> ParityError=1 with ReadValid

Source files
------------

// File: rtl/acc_mem_pkg.sv
// acc_mem_pkg: shared state encodings, default widths and parity helper for the accumulator memory (ACC_MEM_PARITY_EN adds parity)
package acc_mem_pkg;
  typedef enum logic {S_INIT, S_IDLE} state_t;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 6;
  function automatic logic parity_of(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/acc_mem_if.sv
// acc_mem_if: request/response bundle between the accumulator controller and its memory (ACC_MEM_PARITY_EN adds parity_error)
interface acc_mem_if import acc_mem_pkg::*; #(parameter int DATA_W = DEF_DATA_W, parameter int ADDR_W = DEF_ADDR_W);
  logic [ADDR_W-1:0] address;
  logic read_enable;
  logic write_enable;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic read_valid;
  logic mem_ready;
`ifdef ACC_MEM_PARITY_EN
  logic parity_error;
  modport master(output address, read_enable, write_enable, write_data, input read_data, read_valid, mem_ready, parity_error);
  modport slave(input address, read_enable, write_enable, write_data, output read_data, read_valid, mem_ready, parity_error);
`else
  modport master(output address, read_enable, write_enable, write_data, input read_data, read_valid, mem_ready);
  modport slave(input address, read_enable, write_enable, write_data, output read_data, read_valid, mem_ready);
`endif
endinterface

// File: rtl/acc_mem_array.sv
// acc_mem_array: plain 1W/1R storage with registered read; read returns the pre-write word on a same-address collision
module acc_mem_array #(parameter int W = 16, parameter int ADDR_W = 6) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);
  logic [W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/acc_mem_responder.sv
// acc_mem_responder: cleared-on-reset word memory with 2-stage read pipeline and write-first bypass (ACC_MEM_PARITY_EN adds parity)
module acc_mem_responder import acc_mem_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input logic clk,
  input logic rst,
  acc_mem_if.slave bus
);
`ifdef ACC_MEM_PARITY_EN
  localparam int W = DATA_W + 1;
`else
  localparam int W = DATA_W;
`endif
  state_t state, state_d;
  logic [ADDR_W-1:0] cnt, s1_addr, waddr;
  logic s1_valid, s2_valid, byp, we, wr_req;
  logic [W-1:0] wword, rword, byp_word, s2_word;
  function automatic logic [W-1:0] enc(input logic [DATA_W-1:0] d);
`ifdef ACC_MEM_PARITY_EN
    return {parity_of(64'(d)), d};
`else
    return d;
`endif
  endfunction
  always_comb begin
    bus.mem_ready = state == S_IDLE;
    wr_req = bus.mem_ready && bus.write_enable;
    state_d = (state == S_INIT && &cnt) ? S_IDLE : state;
    we = !rst && (state == S_INIT || wr_req);
    waddr = state == S_INIT ? cnt : bus.address;
    wword = enc(state == S_INIT ? INIT_VALUE : bus.write_data);
    s2_word = byp ? byp_word : rword;
  end
  always_ff @(posedge clk) state <= rst ? S_INIT : state_d;
  // byp catches a write landing on the edge the array reads the stage-1 address
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      byp <= 1'b0;
      bus.read_valid <= 1'b0;
      bus.read_data <= '0;
`ifdef ACC_MEM_PARITY_EN
      bus.parity_error <= 1'b0;
`endif
    end else begin
      cnt <= state == S_INIT ? cnt + 1'b1 : cnt;
      s1_valid <= bus.mem_ready && bus.read_enable && !bus.write_enable;
      s1_addr <= bus.address;
      s2_valid <= s1_valid;
      byp <= wr_req && bus.address == s1_addr;
      byp_word <= wword;
      bus.read_valid <= s2_valid;
      if (s2_valid) bus.read_data <= s2_word[DATA_W-1:0];
`ifdef ACC_MEM_PARITY_EN
      bus.parity_error <= s2_valid && (parity_of(64'(s2_word[DATA_W-1:0])) != s2_word[DATA_W]);
`endif
    end
  end
  acc_mem_array #(.W(W), .ADDR_W(ADDR_W)) u_array (
    .clk(clk), .we(we), .waddr(waddr), .wdata(wword), .raddr(s1_addr), .rdata(rword)
  );
endmodule

// File: tb/tb_acc_mem_responder.sv
// tb_acc_mem_responder: directed stimulus with a queue scoreboard checking read data, pulse timing and parity flag
module tb_acc_mem_responder;
  import acc_mem_pkg::*;
  typedef struct {logic [15:0] d; logic pe; int due;} exp_t;
  logic clk = 0, rst = 1;
  int edges = 0, total = 0, passed = 0, n;
  exp_t q[$];
  acc_mem_if bus();
  acc_mem_responder dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;
  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic op(input logic re, input logic we, input logic [5:0] a, input logic [15:0] d, input bit ex, input logic [15:0] ed, input logic pe);
    bus.read_enable = re;
    bus.write_enable = we;
    bus.address = a;
    bus.write_data = d;
    if (ex) q.push_back('{ed, pe, edges + 3});
    @(negedge clk);
  endtask
  task automatic rd(input logic [5:0] a, input logic [15:0] ed, input logic pe = 1'b0);
    op(1'b1, 1'b0, a, 16'h0, 1'b1, ed, pe);
  endtask
  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    op(1'b0, 1'b1, a, d, 1'b0, 16'h0, 1'b0);
  endtask
  task automatic idle(input int k);
    repeat (k) op(1'b0, 1'b0, 6'd0, 16'h0, 1'b0, 16'h0, 1'b0);
  endtask
  task automatic reset_chk(input string tag);
    check(bus.read_valid === 1'b0, {tag, "_valid"}, 32'(bus.read_valid), 0);
    check(bus.mem_ready === 1'b0, {tag, "_ready"}, 32'(bus.mem_ready), 0);
    check(bus.read_data === 16'h0, {tag, "_data"}, 32'(bus.read_data), 0);
  endtask
  task automatic wait_ready(output int cyc);
    bus.read_enable = 1'b0;
    bus.write_enable = 1'b0;
    cyc = 0;
    while (!bus.mem_ready && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask
  always @(negedge clk) if (bus.read_valid) begin
    check(q.size() > 0, "spurious_valid", 32'(bus.read_data), 0);
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check(bus.read_data === e.d && edges == e.due
`ifdef ACC_MEM_PARITY_EN
        && bus.parity_error === e.pe
`endif
        , $sformatf("read_at%0d_due%0d", edges, e.due), 32'(bus.read_data), 32'(e.d));
    end
  end
  initial begin
    bus.read_enable = 1'b0;
    bus.write_enable = 1'b0;
    bus.address = '0;
    bus.write_data = '0;
    @(negedge clk);
    reset_chk("reset");
    rst = 1'b0;
    wait_ready(n);
    check(n == 64, "sweep_cycles", 32'(n), 64);
    rd(6'd0, 16'h0); rd(6'd40, 16'h0); rd(6'd63, 16'h0); idle(4);
    wr(6'd5, 16'h1234);
    repeat (3) rd(6'd5, 16'h1234);
    idle(4);
    for (int i = 0; i < 8; i++) wr(6'(i), 16'(i + 1));
    for (int i = 0; i < 8; i++) rd(6'(i), 16'(i + 1));
    idle(4);
    check(bus.read_data === 16'h0008 && bus.read_valid === 1'b0, "hold_data", 32'(bus.read_data), 32'h8);
    rd(6'd9, 16'hBEEF);
    wr(6'd9, 16'hBEEF);
    idle(4);
    op(1'b1, 1'b1, 6'd3, 16'h00AA, 1'b0, 16'h0, 1'b0);
    idle(4);
    rd(6'd3, 16'h00AA);
    idle(4);
    op(1'b1, 1'b0, 6'd1, 16'h0, 1'b0, 16'h0, 1'b0);
    op(1'b1, 1'b0, 6'd2, 16'h0, 1'b0, 16'h0, 1'b0);
    bus.read_enable = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    reset_chk("midreset");
    rst = 1'b0;
    idle(10);
    wr(6'd0, 16'hFFFF);
    op(1'b1, 1'b0, 6'd0, 16'h0, 1'b0, 16'h0, 1'b0);
    wait_ready(n);
    check(bus.mem_ready === 1'b1, "ready_after_reset", 32'(bus.mem_ready), 1);
    rd(6'd5, 16'h0); rd(6'd0, 16'h0); rd(6'd9, 16'h0); idle(4);
`ifdef ACC_MEM_PARITY_EN
    wr(6'd7, 16'h00F0);
    idle(1);
    dut.u_array.mem[7][16] = ~dut.u_array.mem[7][16];
    rd(6'd7, 16'h00F0, 1'b1);
    rd(6'd5, 16'h0, 1'b0);
    idle(4);
`endif
    check(q.size() == 0, "all_reads_returned", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
